// File: rtl/kws_pkg.sv
// Shared register offsets, bit positions and sequencer states for the keyword-spotting control block.
package kws_pkg;

  localparam logic [2:0] ADR_CTRL      = 3'd0;
  localparam logic [2:0] ADR_STATUS    = 3'd1;
  localparam logic [2:0] ADR_SAMPLE    = 3'd2;
  localparam logic [2:0] ADR_RESULT    = 3'd3;
  localparam logic [2:0] ADR_FRAME_CNT = 3'd4;
  localparam logic [2:0] ADR_TIMEOUT   = 3'd5;
  localparam logic [2:0] ADR_THRESH    = 3'd6;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_SCLR_BIT   = 2;

  localparam int STS_RV_BIT    = 3;
  localparam int STS_OVF_BIT   = 4;
  localparam int STS_TMO_BIT   = 5;
  localparam int STS_LEVEL_LSB = 8;
  localparam int RES_SCORE_LSB = 16;

  // state    | meaning
  // IDLE     | sequencer disabled, waiting for enable
  // STREAM   | forwarding FIFO samples to the feature engine
  // WAIT_FE  | frame sent, waiting for fe_done
  // INFER    | one-cycle nn_start, timeout counter loaded
  // WAIT_NN  | waiting for nn_done or timeout
  // REPORT   | one-cycle gap before the next frame
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STREAM  = 3'd1,
    ST_WAIT_FE = 3'd2,
    ST_INFER   = 3'd3,
    ST_WAIT_NN = 3'd4,
    ST_REPORT  = 3'd5
  } state_e;

endpackage

// File: rtl/kws_sample_fifo.sv
// Synchronous sample FIFO with flush; a push while full is accepted only if a pop happens in the same cycle.
module kws_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/kws_seq_ctrl.sv
// Wishbone control/sequencing for the keyword-spotting core: sample FIFO -> feature engine -> classifier.
// Optional score threshold register enabled by defining KWS_SCORE_THRESH_EN.
module kws_seq_ctrl
  import kws_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256,
  parameter int CLASS_W    = 4,
  parameter int SCORE_W    = 16,
  parameter int TMO_W      = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic                fe_valid,
  input  logic                fe_ready,
  output logic [SAMPLE_W-1:0] fe_data,
  input  logic                fe_done,
  output logic                nn_start,
  input  logic                nn_done,
  input  logic [CLASS_W-1:0]  nn_class,
  input  logic [SCORE_W-1:0]  nn_score,
  output logic                irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(FRAME_LEN - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     smp_cnt_q, smp_cnt_d;
  logic                 en_q, en_d, irq_en_q, irq_en_d;
  logic                 rv_q, rv_d, ovf_q, ovf_d, tmo_flag_q, tmo_flag_d;
  logic [CLASS_W-1:0]   class_q, class_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [31:0]          frame_cnt_q, frame_cnt_d;
  logic [TMO_W-1:0]     timeout_q, timeout_d, tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_arm_q, tmo_arm_d;
  logic                 irq_q, irq_d;
  logic                 ack_q;
  logic [31:0]          dat_o_q, rdata;
`ifdef KWS_SCORE_THRESH_EN
  logic [SCORE_W-1:0]   thresh_q, thresh_d;
`endif

  logic                 wb_req, wb_wr, wb_rd;
  logic [2:0]           adr;
  logic                 soft_clr, score_pass;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0]  fifo_head;
  logic [LVL_W-1:0]     fifo_level;
  logic                 unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i};

  assign adr      = wbs_adr_i[4:2];
  assign wb_req   = wbs_cyc_i && wbs_stb_i && !ack_q;
  assign wb_wr    = wb_req && wbs_we_i;
  assign wb_rd    = wb_req && !wbs_we_i;
  assign soft_clr = wb_wr && (adr == ADR_CTRL) && wbs_dat_i[CTRL_SCLR_BIT];

  assign fe_valid  = (state_q == ST_STREAM) && en_q && !fifo_empty;
  assign fe_data   = fe_valid ? fifo_head : '0;
  assign nn_start  = (state_q == ST_INFER) && en_q;
  assign fifo_pop  = fe_valid && fe_ready;
  assign fifo_push = wb_wr && (adr == ADR_SAMPLE);

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_o_q;
  assign irq       = irq_q;

`ifdef KWS_SCORE_THRESH_EN
  assign score_pass = (nn_score >= thresh_q);
`else
  assign score_pass = 1'b1;
`endif

  kws_sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .flush_i     (soft_clr),
    .push_i      (fifo_push),
    .push_data_i (wbs_dat_i[SAMPLE_W-1:0]),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  always_comb begin
    rdata = '0;
    case (adr)
      ADR_CTRL: begin
        rdata[CTRL_EN_BIT]     = en_q;
        rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      ADR_STATUS: begin
        rdata[2:0]                    = state_q;
        rdata[STS_RV_BIT]             = rv_q;
        rdata[STS_OVF_BIT]            = ovf_q;
        rdata[STS_TMO_BIT]            = tmo_flag_q;
        rdata[STS_LEVEL_LSB +: LVL_W] = fifo_level;
      end
      ADR_RESULT: begin
        rdata[RES_SCORE_LSB +: SCORE_W] = score_q;
        rdata[0 +: CLASS_W]             = class_q;
      end
      ADR_FRAME_CNT: rdata = frame_cnt_q;
      ADR_TIMEOUT:   rdata[0 +: TMO_W] = timeout_q;
`ifdef KWS_SCORE_THRESH_EN
      ADR_THRESH:    rdata[0 +: SCORE_W] = thresh_q;
`endif
      default:       rdata = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    en_d        = en_q;
    irq_en_d    = irq_en_q;
    rv_d        = rv_q;
    ovf_d       = ovf_q;
    tmo_flag_d  = tmo_flag_q;
    class_d     = class_q;
    score_d     = score_q;
    frame_cnt_d = frame_cnt_q;
    timeout_d   = timeout_q;
    tmo_cnt_d   = tmo_cnt_q;
    tmo_arm_d   = tmo_arm_q;
`ifdef KWS_SCORE_THRESH_EN
    thresh_d    = thresh_q;
    if (wb_wr && adr == ADR_THRESH) thresh_d = wbs_dat_i[SCORE_W-1:0];
`endif

    if (wb_wr && adr == ADR_CTRL) begin
      en_d     = wbs_dat_i[CTRL_EN_BIT];
      irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
    end
    if (wb_wr && adr == ADR_TIMEOUT) timeout_d = wbs_dat_i[TMO_W-1:0];
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (wb_rd && adr == ADR_RESULT) rv_d = 1'b0;

    if (!en_q) begin
      state_d   = ST_IDLE;
      smp_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_STREAM;
        ST_STREAM: begin
          if (fifo_pop) begin
            if (smp_cnt_q == SMP_LAST) begin
              smp_cnt_d = '0;
              state_d   = ST_WAIT_FE;
            end else begin
              smp_cnt_d = smp_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WAIT_FE: if (fe_done) state_d = ST_INFER;
        ST_INFER: begin
          tmo_cnt_d = timeout_q;
          tmo_arm_d = (timeout_q != '0);
          state_d   = ST_WAIT_NN;
        end
        ST_WAIT_NN: begin
          // nn_done wins over a timeout expiring in the same cycle
          if (nn_done) begin
            class_d     = nn_class;
            score_d     = nn_score;
            frame_cnt_d = frame_cnt_q + 32'd1;
            if (score_pass) rv_d = 1'b1;
            state_d     = ST_REPORT;
          end else if (tmo_arm_q && tmo_cnt_q == '0) begin
            tmo_flag_d = 1'b1;
            state_d    = ST_REPORT;
          end else if (tmo_cnt_q != '0) begin
            tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
          end
        end
        ST_REPORT: state_d = ST_STREAM;
        default:   state_d = ST_IDLE;
      endcase
    end

    if (soft_clr) begin
      state_d     = ST_IDLE;
      smp_cnt_d   = '0;
      rv_d        = 1'b0;
      ovf_d       = 1'b0;
      tmo_flag_d  = 1'b0;
      frame_cnt_d = '0;
    end

    irq_d = irq_en_d && rv_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      smp_cnt_q   <= '0;
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      rv_q        <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_flag_q  <= 1'b0;
      class_q     <= '0;
      score_q     <= '0;
      frame_cnt_q <= '0;
      timeout_q   <= '0;
      tmo_cnt_q   <= '0;
      tmo_arm_q   <= 1'b0;
      irq_q       <= 1'b0;
      ack_q       <= 1'b0;
      dat_o_q     <= '0;
`ifdef KWS_SCORE_THRESH_EN
      thresh_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      rv_q        <= rv_d;
      ovf_q       <= ovf_d;
      tmo_flag_q  <= tmo_flag_d;
      class_q     <= class_d;
      score_q     <= score_d;
      frame_cnt_q <= frame_cnt_d;
      timeout_q   <= timeout_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_arm_q   <= tmo_arm_d;
      irq_q       <= irq_d;
      ack_q       <= wb_req;
      dat_o_q     <= wb_rd ? rdata : 32'd0;
`ifdef KWS_SCORE_THRESH_EN
      thresh_q    <= thresh_d;
`endif
    end
  end

endmodule
